// File: rtl/rv_wb_stage.sv
// RV32I writeback stage: turns each accepted instruction into at most one
// register-file write, stalling on loads until the data-memory word returns.
module rv_wb_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] CSR,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rd_we,
  output logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [31:0]      instret
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [0:0]       state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic [2:0]       ld_funct3_q, ld_funct3_d;
  logic [1:0]       ld_off_q, ld_off_d;
  logic             rd_we_q, rd_we_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [31:0]      instret_q, instret_d;

  // Writeback candidate for this cycle, shared by the ALU and load paths.
  logic             done;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_val;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign ld_byte = 8'(mem_rdata >> {ld_off_q, 3'b000});
  assign ld_half = 16'(mem_rdata >> {ld_off_q[1], 4'b0000});

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    instret_d   = instret_q;
    done        = 1'b0;
    wb_en       = 1'b0;
    wb_rd       = rd;
    wb_val      = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_LOAD) begin
            state_d     = S_WAIT_MEM;
            ld_rd_d     = rd;
            ld_funct3_d = funct3;
            ld_off_d    = alu_res[1:0];
          end else begin
            done = 1'b1;
            case (opcode)
              OP_REG, OP_IMM, OP_AUIPC: begin wb_en = 1'b1; wb_val = alu_res; end
              OP_LUI:                   begin wb_en = 1'b1; wb_val = imm; end
              OP_JAL, OP_JALR:          begin wb_en = 1'b1; wb_val = PC + WIDTH'(4); end
              OP_SYSTEM:                begin wb_en = (funct3 != 3'd0); wb_val = CSR; end
              default:                  wb_en = 1'b0;
            endcase
          end
        end
      end
      default: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          done    = 1'b1;
          wb_rd   = ld_rd_q;
          case (ld_funct3_q)
            3'd0: begin wb_en = 1'b1; wb_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte}; end
            3'd4: begin wb_en = 1'b1; wb_val = {{(WIDTH-8){1'b0}}, ld_byte}; end
            3'd1: begin wb_en = 1'b1; wb_val = {{(WIDTH-16){ld_half[15]}}, ld_half}; end
            3'd5: begin wb_en = 1'b1; wb_val = {{(WIDTH-16){1'b0}}, ld_half}; end
            3'd2: begin wb_en = 1'b1; wb_val = mem_rdata; end
            default: wb_en = 1'b0;
          endcase
        end
      end
    endcase

    if (done) begin
      instret_d = instret_q + 32'd1;
      if (wb_en && (wb_rd != 5'd0)) begin
        rd_we_d   = 1'b1;
        rd_addr_d = wb_rd;
        rd_data_d = wb_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      instret_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      instret_q   <= instret_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign rd_we    = rd_we_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign instret  = instret_q;

endmodule
